// File: rtl/led_bar_sequencer.sv
// led_bar_sequencer
//  Drives the 8-LED bar through a 16-step pattern. The step rate comes from a
//  synchronous prescaler; there is no clock gating. Buttons arrive already
//  debounced as one-cycle pulses.
// Ports
//  CLK    system clock (posedge)
//  RST_N  asynchronous active-low reset
//  START  pulse: start from IDLE, resume from HOLD
//  STOP   pulse: pause from RUN, clear from HOLD (wins over START)
//  MODE   pattern select, captured on START in IDLE
//  LOOP   1 = wrap after step 15, 0 = finish after step 15
//  O      LED bar (registered), O[7] is the top LED
//  STEP   current step index (registered)
//  BUSY   high in RUN or HOLD (registered)
//  DONE   one-cycle pulse when a non-looping sequence completes
module led_bar_sequencer #(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned DIV_W    = 24
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic                STOP,
  input  logic [1:0]          MODE,
  input  logic                LOOP,
  output logic [7:0]          O,
  output logic [3:0]          STEP,
  output logic                BUSY,
  output logic                DONE
);

  localparam int unsigned LED_W  = 8;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned MODE_W = 2;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(15);
  localparam logic [DIV_W-1:0]  TICK_MAX  = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    presc;
  logic [MODE_W-1:0]   mode_q;
  logic                tick;
  logic [STEP_W-1:0]   step_nxt;

  // Pattern lookup: LED image for mode m at step s.
  function automatic logic [LED_W-1:0] pat(input logic [MODE_W-1:0] m,
                                           input logic [STEP_W-1:0] s);
    logic [STEP_W-1:0] len;
    logic [LED_W-1:0]  r;
    // Bar length rises 1..8 over steps 0..7, then falls 8..1 over steps 8..15.
    len = s[3] ? STEP_W'(5'd16 - {1'b0, s}) : STEP_W'(s + STEP_W'(1));
    case (m)
      2'd0:    r = ~(8'hFF >> len);
      2'd1:    r = s[3] ? (8'h01 << s[2:0]) : (8'h80 >> s[2:0]);
      2'd2:    r = s[0] ? 8'h55 : 8'hAA;
      default: r = {4'h0, s};
    endcase
    return r;
  endfunction

  assign tick     = (presc == TICK_MAX);
  assign step_nxt = STEP + STEP_W'(1);

  // Run-control FSM with registered LED/step/status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      presc  <= '0;
      mode_q <= '0;
      O      <= '0;
      STEP   <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START && !STOP) begin
            state  <= ST_RUN;
            BUSY   <= 1'b1;
            presc  <= '0;
            STEP   <= '0;
            mode_q <= MODE;
            O      <= pat(MODE, '0);
          end
        end
        ST_RUN: begin
          if (tick) begin
            presc <= '0;
            if (STEP == LAST_STEP && !LOOP) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
              O     <= '0;
              STEP  <= '0;
              DONE  <= 1'b1;
            end else begin
              // Wraps 15->0 naturally when looping; a STOP on this edge
              // lets the step land before pausing.
              STEP <= step_nxt;
              O    <= pat(mode_q, step_nxt);
              if (STOP) state <= ST_HOLD;
            end
          end else if (STOP) begin
            state <= ST_HOLD;
          end else begin
            presc <= presc + DIV_W'(1);
          end
        end
        ST_HOLD: begin
          if (STOP) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            presc <= '0;
            O     <= '0;
            STEP  <= '0;
          end else if (START) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bar_sequencer.sv
// tb_led_bar_sequencer
//  Scoreboard bench for led_bar_sequencer with TICK_DIV=4. Each driven cycle
//  pushes the expected post-edge outputs; a monitor pops and compares them
//  just after the following rising edge.
module tb_led_bar_sequencer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DIV_W    = 3;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic       STOP;
  logic [1:0] MODE;
  logic       LOOP;
  logic [7:0] O;
  logic [3:0] STEP;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] o;
    logic [3:0] step;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  localparam logic [7:0] FILL_T [16] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                                         8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
  localparam logic [7:0] CHASE_T [16] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                          8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  led_bar_sequencer #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .STOP  (STOP),
    .MODE  (MODE),
    .LOOP  (LOOP),
    .O     (O),
    .STEP  (STEP),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pat(input int m, input int s);
    case (m)
      0:       return FILL_T[s];
      1:       return CHASE_T[s];
      2:       return (s % 2 == 1) ? 8'h55 : 8'hAA;
      default: return 8'(s);
    endcase
  endfunction

  // Drive inputs for one cycle and queue what the outputs must be after the edge.
  task automatic drive(input logic st, input logic sp, input logic [1:0] md, input logic lp,
                       input string tag, input logic [7:0] eo, input logic [3:0] es,
                       input logic eb, input logic ed);
    exp_t e;
    @(negedge CLK);
    START = st;
    STOP  = sp;
    MODE  = md;
    LOOP  = lp;
    e.tag  = tag;
    e.o    = eo;
    e.step = es;
    e.busy = eb;
    e.done = ed;
    sb.push_back(e);
  endtask

  // Monitor: compare queued expectations just after each rising edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, " O"},    32'(O),    32'(e.o));
      chk({e.tag, " STEP"}, 32'(STEP), 32'(e.step));
      chk({e.tag, " BUSY"}, 32'(BUSY), 32'(e.busy));
      chk({e.tag, " DONE"}, 32'(DONE), 32'(e.done));
    end
  end

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
    MODE  = 2'd0;
    LOOP  = 1'b0;
    #23;
    chk("reset O",    32'(O),    32'h0);
    chk("reset STEP", 32'(STEP), 32'h0);
    chk("reset BUSY", 32'(BUSY), 32'h0);
    chk("reset DONE", 32'(DONE), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Idle stays idle; START with STOP in IDLE does nothing.
    drive(1'b0, 1'b0, 2'd0, 1'b0, "idle", 8'h00, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 1'b0, "idle_both", 8'h00, 4'd0, 1'b0, 1'b0);

    // 1: FILL, no loop, completes with a single DONE pulse.
    drive(1'b1, 1'b0, 2'd0, 1'b0, "t1", 8'h80, 4'd0, 1'b1, 1'b0);
    for (int j = 1; j < 64; j++)
      drive(1'b0, 1'b0, 2'd0, 1'b0, "t1", exp_pat(0, j / 4), 4'(j / 4), 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, "t1_done", 8'h00, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 2'd0, 1'b0, "t1_after", 8'h00, 4'd0, 1'b0, 1'b0);

    // 2: CHASE looping; MODE change and START mid-run ignored; STOP on a tick edge.
    drive(1'b1, 1'b0, 2'd1, 1'b1, "t2", 8'h80, 4'd0, 1'b1, 1'b0);
    for (int j = 1; j < 72; j++)
      drive(j == 30, 1'b0, (j >= 20) ? 2'd2 : 2'd1, 1'b1, "t2",
            exp_pat(1, (j / 4) % 16), 4'((j / 4) % 16), 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'd2, 1'b1, "t2_stop_tick", exp_pat(1, 2), 4'd2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      drive(1'b0, 1'b0, 2'd2, 1'b1, "t2_hold", exp_pat(1, 2), 4'd2, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'd2, 1'b1, "t2_clear", 8'h00, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'd2, 1'b1, "t2_idle", 8'h00, 4'd0, 1'b0, 1'b0);

    // 3: BIN, pause at step 5 / prescaler 2, resume without losing a cycle.
    drive(1'b1, 1'b0, 2'd3, 1'b0, "t3", 8'h00, 4'd0, 1'b1, 1'b0);
    for (int j = 1; j < 23; j++)
      drive(1'b0, 1'b0, 2'd3, 1'b0, "t3", exp_pat(3, j / 4), 4'(j / 4), 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 1'b0, "t3_stop", 8'h05, 4'd5, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++)
      drive(1'b0, 1'b0, 2'd1, 1'b0, "t3_hold", 8'h05, 4'd5, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'd3, 1'b0, "t3_resume", 8'h05, 4'd5, 1'b1, 1'b0);
    for (int j = 23; j < 64; j++)
      drive(1'b0, 1'b0, 2'd3, 1'b0, "t3_run", exp_pat(3, j / 4), 4'(j / 4), 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'd3, 1'b0, "t3_done", 8'h00, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 2'd3, 1'b0, "t3_after", 8'h00, 4'd0, 1'b0, 1'b0);

    // 4: START+STOP together in RUN pauses; STOP in HOLD clears without DONE.
    drive(1'b1, 1'b0, 2'd0, 1'b1, "t4", 8'h80, 4'd0, 1'b1, 1'b0);
    for (int j = 1; j < 6; j++)
      drive(1'b0, 1'b0, 2'd0, 1'b1, "t4", exp_pat(0, j / 4), 4'(j / 4), 1'b1, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 1'b1, "t4_both", 8'hC0, 4'd1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      drive(1'b0, 1'b0, 2'd0, 1'b1, "t4_hold", 8'hC0, 4'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 1'b1, "t4_clear", 8'h00, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 1'b1, "t4_idle", 8'h00, 4'd0, 1'b0, 1'b0);

    // 5: asynchronous reset mid-run, then IDLE until START.
    drive(1'b1, 1'b0, 2'd2, 1'b1, "t5", 8'hAA, 4'd0, 1'b1, 1'b0);
    for (int j = 1; j < 10; j++)
      drive(1'b0, 1'b0, 2'd2, 1'b1, "t5", exp_pat(2, j / 4), 4'(j / 4), 1'b1, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    STOP  = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("t5_rst O",    32'(O),    32'h0);
    chk("t5_rst STEP", 32'(STEP), 32'h0);
    chk("t5_rst BUSY", 32'(BUSY), 32'h0);
    chk("t5_rst DONE", 32'(DONE), 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++)
      drive(1'b0, 1'b0, 2'd2, 1'b1, "t5_idle", 8'h00, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd3, 1'b0, "t5_restart", 8'h00, 4'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 1'b0, "t5_pause", 8'h00, 4'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 1'b0, "t5_clear", 8'h00, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'd3, 1'b0, "t5_end", 8'h00, 4'd0, 1'b0, 1'b0);

    @(posedge CLK);
    #3;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
